pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control for a 5-stage core: load-use interlock, branch redirect, data-memory wait,
// trap/mret entry with a fixed-length drain, and a saturating count of PC-stall cycles.
module pipeline_ctrl #(
    parameter int unsigned TRAP_DRAIN = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_load,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_redirect,
    input  logic        i_mem_valid,
    input  logic        i_mem_req,
    input  logic        i_mem_ready,
    input  logic        i_mem_trap,
    input  logic        i_mem_mret,
    output logic        o_stall_pc,
    output logic        o_stall_ifid,
    output logic        o_stall_idex,
    output logic        o_stall_exmem,
    output logic        o_flush_ifid,
    output logic        o_flush_idex,
    output logic        o_flush_exmem,
    output logic [1:0]  o_pc_sel,
    output logic [1:0]  o_state,
    output logic [15:0] o_stall_cnt
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StMemWait = 2'd1;
    localparam logic [1:0] StTrap    = 2'd2;

    localparam logic [1:0] PcSeq    = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcTrap   = 2'd2;
    localparam logic [1:0] PcMepc   = 2'd3;

    localparam logic [3:0] DrainInit = 4'(TRAP_DRAIN - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  trap_cnt_q, trap_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_use, mem_wait, trap_event;

    assign load_use = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                      ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
    assign mem_wait   = i_mem_req & ~i_mem_ready;
    // A trap cannot be taken while its own memory access is still outstanding.
    assign trap_event = i_mem_valid & (i_mem_trap | i_mem_mret) & ~mem_wait;

    always_comb begin
        o_stall_pc    = 1'b0;
        o_stall_ifid  = 1'b0;
        o_stall_idex  = 1'b0;
        o_stall_exmem = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_flush_exmem = 1'b0;
        o_pc_sel      = PcSeq;
        state_d       = state_q;
        trap_cnt_d    = trap_cnt_q;

        if (i_rst) begin
            o_flush_ifid  = 1'b1;
            o_flush_idex  = 1'b1;
            o_flush_exmem = 1'b1;
            state_d       = StRun;
            trap_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                StTrap: begin
                    o_stall_pc    = 1'b1;
                    o_flush_ifid  = 1'b1;
                    o_flush_idex  = 1'b1;
                    o_flush_exmem = 1'b1;
                    if (trap_cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        trap_cnt_d = trap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (trap_event) begin
                        o_flush_ifid  = 1'b1;
                        o_flush_idex  = 1'b1;
                        o_flush_exmem = 1'b1;
                        o_pc_sel      = (i_mem_mret && !i_mem_trap) ? PcMepc : PcTrap;
                        state_d       = StTrap;
                        trap_cnt_d    = DrainInit;
                    end else if (mem_wait) begin
                        o_stall_pc    = 1'b1;
                        o_stall_ifid  = 1'b1;
                        o_stall_idex  = 1'b1;
                        o_stall_exmem = 1'b1;
                        state_d       = StMemWait;
                    end else if (i_ex_redirect) begin
                        // Redirect squashes the dependent ID instruction, so no interlock.
                        o_flush_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                        o_pc_sel     = PcBranch;
                        state_d      = StRun;
                    end else if (load_use) begin
                        o_stall_pc   = 1'b1;
                        o_stall_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                        state_d      = StRun;
                    end else begin
                        state_d = StRun;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall_pc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StRun;
            trap_cnt_q  <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            trap_cnt_q  <= trap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipeline_ctrl;

    localparam int unsigned TRAP_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        uses1, uses2, ex_valid, ex_is_load, ex_redirect;
    logic        mem_valid, mem_req, mem_ready, mem_trap, mem_mret;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  pc_sel, state;
    logic [15:0] stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: 0 RUN, 1 MEM_WAIT, 2 TRAP; m_left = TRAP cycles still to spend.
    int          m_state, m_left, n_state, n_left;
    int unsigned m_cnt, n_cnt;
    logic [3:0]  e_stall;
    logic [2:0]  e_flush;
    logic [1:0]  e_pc;

    wire [3:0] o_stall = {stall_pc, stall_ifid, stall_idex, stall_exmem};
    wire [2:0] o_flush = {flush_ifid, flush_idex, flush_exmem};
    wire [8:0] obs     = {o_stall, o_flush, pc_sel};

    always #5 clk = ~clk;

    pipeline_ctrl #(.TRAP_DRAIN(TRAP_DRAIN)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
        .i_ex_valid(ex_valid), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
        .i_ex_redirect(ex_redirect), .i_mem_valid(mem_valid),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .i_mem_trap(mem_trap), .i_mem_mret(mem_mret),
        .o_stall_pc(stall_pc), .o_stall_ifid(stall_ifid),
        .o_stall_idex(stall_idex), .o_stall_exmem(stall_exmem),
        .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex), .o_flush_exmem(flush_exmem),
        .o_pc_sel(pc_sel), .o_state(state), .o_stall_cnt(stall_cnt)
    );

    task automatic predict();
        bit lu, mw, tev;
        lu  = ex_valid && ex_is_load && (ex_rd != 0) &&
              ((uses1 && id_rs1 == ex_rd) || (uses2 && id_rs2 == ex_rd));
        mw  = mem_req && !mem_ready;
        tev = mem_valid && (mem_trap || mem_mret) && !mw;
        e_stall = 4'b0000; e_flush = 3'b000; e_pc = 2'd0;
        n_state = m_state; n_left = m_left;
        if (rst) begin
            e_flush = 3'b111; n_state = 0; n_left = 0;
        end else if (m_state == 2) begin
            e_stall = 4'b1000; e_flush = 3'b111;
            n_left  = m_left - 1;
            if (n_left == 0) n_state = 0;
        end else if (tev) begin
            e_flush = 3'b111; e_pc = mem_trap ? 2'd2 : 2'd3;
            n_state = 2; n_left = TRAP_DRAIN;
        end else if (mw) begin
            e_stall = 4'b1111; n_state = 1;
        end else if (ex_redirect) begin
            e_flush = 3'b110; e_pc = 2'd1; n_state = 0;
        end else if (lu) begin
            e_stall = 4'b1100; e_flush = 3'b010; n_state = 0;
        end else begin
            n_state = 0;
        end
        if (rst) n_cnt = 0;
        else if (e_stall[3]) n_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        else n_cnt = m_cnt;
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        m_state = n_state; m_left = n_left; m_cnt = n_cnt;
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        uses1 = 1'b0; uses2 = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        ex_redirect = 1'b0; mem_valid = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        mem_trap = 1'b0; mem_mret = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        uses1 = 1'b1; mem_req = 1'b1;
        tick();
        settle();
        n_checks++;
        if (obs !== 9'b0000_111_00) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", obs, 9'b0000_111_00);
        end
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d cnt %0d want 0 0", state, stall_cnt);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs2 = 5'd5; uses2 = 1'b1; id_rs1 = 5'd3; uses1 = 1'b1;
        settle();
        n_checks++;
        if (obs !== 9'b1100_010_00) begin
            n_fail++;
            $display("FAIL load_use_outs: got %b want %b", obs, 9'b1100_010_00);
        end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (stall_cnt !== 16'd1 || obs !== 9'd0) begin
            n_fail++;
            $display("FAIL load_use_cnt: got cnt %0d outs %b want 1 %b", stall_cnt, obs, 9'd0);
        end
    endtask

    task automatic test_load_use_x0();
        clear_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; uses2 = 1'b1;
        settle();
        n_checks++;
        if (obs !== 9'd0) begin
            n_fail++;
            $display("FAIL load_use_x0: got %b want %b", obs, 9'd0);
        end
        tick();
        settle();
        n_checks++;
        if (stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_x0_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (obs !== 9'b1111_000_00 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                n_fail++;
                $display("FAIL mem_wait_%0d: got %b st %0d want %b st %0d", i, obs, state,
                         9'b1111_000_00, (i == 0) ? 0 : 1);
            end
            tick();
        end
        ex_redirect = 1'b0;
        mem_ready = 1'b1;
        settle();
        n_checks++;
        if (obs !== 9'd0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL mem_wait_release: got %b st %0d want %b st 1", obs, state, 9'd0);
        end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL mem_wait_end: got st %0d cnt %0d want 0 3", state, stall_cnt);
        end
    endtask

    task automatic test_trap();
        do_reset();
        mem_valid = 1'b1; mem_trap = 1'b1; mem_mret = 1'b1; ex_redirect = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; uses1 = 1'b1;
        settle();
        n_checks++;
        if (obs !== 9'b0000_111_10) begin
            n_fail++;
            $display("FAIL trap_entry: got %b want %b", obs, 9'b0000_111_10);
        end
        tick();
        // Inputs are ignored while draining.
        mem_trap = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_checks++;
            if (state !== 2'd2 || obs !== 9'b1000_111_00) begin
                n_fail++;
                $display("FAIL trap_drain_%0d: got st %0d %b want st 2 %b", k, state, obs,
                         9'b1000_111_00);
            end
            tick();
        end
        clear_inputs();
        settle();
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL trap_exit: got st %0d cnt %0d want 0 2", state, stall_cnt);
        end
    endtask

    task automatic test_mret_reset();
        clear_inputs();
        mem_valid = 1'b1; mem_mret = 1'b1;
        settle();
        n_checks++;
        if (pc_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL mret_pc_sel: got %0d want 3", pc_sel);
        end
        tick();
        clear_inputs();
        rst = 1'b1;
        settle();
        n_checks++;
        if (state !== 2'd2 || obs !== 9'b0000_111_00) begin
            n_fail++;
            $display("FAIL rst_in_trap: got st %0d %b want st 2 %b", state, obs, 9'b0000_111_00);
        end
        tick();
        rst = 1'b0;
        settle();
        n_checks++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_in_trap_after: got st %0d cnt %0d want 0 0", state, stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            uses1       = 1'($urandom);
            uses2       = 1'($urandom);
            ex_valid    = 1'($urandom);
            ex_is_load  = 1'($urandom);
            ex_redirect = ($urandom_range(0, 3) == 0);
            mem_valid   = 1'($urandom);
            mem_req     = ($urandom_range(0, 3) == 0);
            mem_ready   = 1'($urandom);
            mem_trap    = ($urandom_range(0, 15) == 0);
            mem_mret    = ($urandom_range(0, 15) == 0);
            settle();
            n_checks++;
            if (obs !== {e_stall, e_flush, e_pc}) begin
                n_fail++;
                $display("FAIL rand_outs cyc %0d: got %b want %b", c, obs,
                         {e_stall, e_flush, e_pc});
            end
            n_checks++;
            if (state !== 2'(m_state) || stall_cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: got st %0d cnt %0d want st %0d cnt %0d", c,
                         state, stall_cnt, m_state, m_cnt);
            end
            n_checks++;
            if ((o_stall[2:0] & o_flush) !== 3'b000) begin
                n_fail++;
                $display("FAIL rand_exclusive cyc %0d: got stall %b flush %b want disjoint", c,
                         o_stall, o_flush);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 65540; i++) tick();
        settle();
        n_checks++;
        if (stall_cnt !== 16'hFFFF || state !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_cnt: got cnt %h st %0d want ffff st 1", stall_cnt, state);
        end
        tick();
        settle();
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h want ffff", stall_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        m_state = 0; m_left = 0; m_cnt = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_mem_wait();
        test_trap();
        test_mret_reset();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
